// File: rtl/hog_feature_reader_if.sv
// hog_feature_reader_if: valid/ready word stream from the HOG feature reader to its sink
//   m_tdata  - result word
//   m_tvalid - word available
//   m_tready - sink accepts the word
//   m_tlast  - final word of a transfer
interface hog_feature_reader_if #(parameter int QN = 10);
    logic [QN-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);
endinterface

// File: rtl/hog_feature_reader.sv
// hog_feature_reader: reads the four result BRAM banks interleaved and streams the words out
//   aclk, rst          - clock, synchronous active-high reset
//   start              - command pulse, taken only when idle
//   base_addr,word_cnt - first bank address, addresses per bank (4*word_cnt words)
//   busy, done         - transfer in progress, one-cycle completion pulse
//   res_enb_x/addrb_x  - bank read ports, res_doutb_x bank read data
//   m                  - output word stream (master side)
module hog_feature_reader #(
    parameter int RAM_AW     = 17,
    parameter int QN         = 10,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAM_AW-1:0] base_addr,
    input  logic [RAM_AW-1:0] word_cnt,
    output logic              busy,
    output logic              done,
    output logic              res_enb_0,
    output logic              res_enb_1,
    output logic              res_enb_2,
    output logic              res_enb_3,
    output logic [RAM_AW-1:0] res_addrb_0,
    output logic [RAM_AW-1:0] res_addrb_1,
    output logic [RAM_AW-1:0] res_addrb_2,
    output logic [RAM_AW-1:0] res_addrb_3,
    input  logic [QN-1:0]     res_doutb_0,
    input  logic [QN-1:0]     res_doutb_1,
    input  logic [QN-1:0]     res_doutb_2,
    input  logic [QN-1:0]     res_doutb_3,
    hog_feature_reader_if.master m
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]        state;
    logic [RAM_AW-1:0] base, cnt, idx, addr;
    logic [1:0]        bank;
    logic [RD_LAT-1:0] pv;
    logic [1:0]        pb [RD_LAT];
    logic [QN-1:0]     mem [FIFO_DEPTH];
    logic [QN-1:0]     din;
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     count, inflight;
    logic [RAM_AW+1:0] beat, last_beat;
    logic              issue, push, pop;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pv[i]);
    end
    // credit rule: a read is only launched if its word is guaranteed a FIFO slot
    assign issue = state == RUN && (count + inflight) < CW'(FIFO_DEPTH);
    assign addr = base + idx;
    assign res_enb_0 = issue && bank == 2'd0;
    assign res_enb_1 = issue && bank == 2'd1;
    assign res_enb_2 = issue && bank == 2'd2;
    assign res_enb_3 = issue && bank == 2'd3;
    assign res_addrb_0 = addr;
    assign res_addrb_1 = addr;
    assign res_addrb_2 = addr;
    assign res_addrb_3 = addr;
    assign push = pv[RD_LAT-1];
    assign din = pb[RD_LAT-1] == 2'd0 ? res_doutb_0 :
                 pb[RD_LAT-1] == 2'd1 ? res_doutb_1 :
                 pb[RD_LAT-1] == 2'd2 ? res_doutb_2 : res_doutb_3;
    assign pop = m.m_tvalid && m.m_tready;
    assign last_beat = {cnt, 2'b00} - 1'b1;
    assign m.m_tvalid = count != '0;
    assign m.m_tdata = m.m_tvalid ? mem[rp] : '0;
    assign m.m_tlast = m.m_tvalid && beat == last_beat;
    assign busy = state == RUN || state == DRAIN;
    assign done = state == DONE;
    // data path: bank-index pipe and FIFO storage need no reset
    always_ff @(posedge aclk) begin
        pb[0] <= bank;
        for (int i = 1; i < RD_LAT; i++) pb[i] <= pb[i-1];
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge aclk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            cnt   <= '0;
            idx   <= '0;
            bank  <= '0;
            pv    <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            beat  <= '0;
        end else begin
            pv[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
            wp    <= wp + PW'(push);
            rp    <= rp + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
            if (pop) beat <= beat + 1'b1;
            if (state == IDLE && start) begin
                base  <= base_addr;
                cnt   <= word_cnt;
                idx   <= '0;
                bank  <= '0;
                beat  <= '0;
                state <= word_cnt == '0 ? DONE : RUN;
            end
            if (issue) begin
                bank <= bank + 1'b1;
                if (bank == 2'd3) idx <= idx + 1'b1;
                if (bank == 2'd3 && idx == cnt - 1'b1) state <= DRAIN;
            end
            // the final word leaving the FIFO implies nothing is in flight or buffered
            if (state == DRAIN && pop && m.m_tlast) state <= DONE;
            if (state == DONE) state <= IDLE;
        end
    end
endmodule

// File: doc/hog_feature_reader.md
Name: hog_feature_reader

Overview:
Read-side engine for the four-bank result BRAM of the image-scaling/HOG subsystem. On a start command it drives the bank read ports (enb/addrb/doutb, QN-bit words). The four banks are read in interleaved order. The words are emitted as a valid/ready stream with full backpressure, so a DMA or AXI-Stream packer can drain HOG features without software polling.

Parameters:
RAM_AW, 17, bank address width
QN, 10, result word width (bits)
RD_LAT, 1, BRAM read latency in cycles, from enb/addrb to doutb valid
FIFO_DEPTH, 4, output buffer depth in words; must be a power of 2 and >= RD_LAT+2

Ports:
aclk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle command pulse; honoured only in IDLE
base_addr  in  RAM_AW  first bank address; latched on an accepted start
word_cnt  in  RAM_AW  addresses per bank; latched on an accepted start; total words = 4*word_cnt
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the transfer is complete
res_enb_0..3  out  1 each  bank read enables
res_addrb_0..3  out  RAM_AW each  bank read addresses
res_doutb_0..3  in  QN each  bank read data
m_tdata  out  QN  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  high with the final word of a transfer

Behaviour:
- Reset (rst=1 at a clock edge):
  - all outputs go to 0; state goes to IDLE; FIFO is emptied.
  - in-flight read data is discarded.
  - rst takes priority over every other event, including mid-transfer.
- State IDLE:
  - start=1 and word_cnt!=0: latch base_addr and word_cnt, go to RUN.
  - start=1 and word_cnt==0: go to DONE; no reads are issued and no beat is produced.
- State RUN: issues reads in the order (addr a, bank 0,1,2,3), then a+1, for a = 0..word_cnt-1.
  - Physical address is (base+a) mod 2^RAM_AW (wrap-around).
  - A read is issued in a cycle only if fifo_count + inflight < FIFO_DEPTH.
  - At most one res_enb_x is high per cycle.
  - All four res_addrb_x show the current address. Address outputs are don't-care when no enb is high.
  - After issuing bank 3 of the last address, go to DRAIN.
- Read return path: the bank index is pipelined RD_LAT stages alongside the read. When the pipe slot is valid, the selected res_doutb is written into the FIFO.
- State DRAIN: wait until inflight==0, the FIFO is empty, and the last beat has handshaked. Then go to DONE.
- State DONE: assert done for exactly one cycle, then go to IDLE.
- busy=1 in RUN and DRAIN only.
- Stream rules:
  - A beat transfers when m_tvalid & m_tready.
  - Once m_tvalid rises, m_tdata and m_tlast hold stable until the handshake.
  - m_tvalid = FIFO not empty.
  - m_tlast is set on word index 4*word_cnt-1 only; this is tracked with an output beat counter.
- Latency, with start accepted at edge N and m_tready=1:
  - res_enb_0=1 in cycle N+1.
  - First m_tvalid in cycle N+2+RD_LAT.
  - Afterwards, one word per cycle with no bubbles.
  - done is asserted in the cycle after the last handshake.
- Boundary cases:
  - start while busy or while in DONE: ignored; latched values are unchanged.
  - FIFO full while reads are in flight cannot occur, because of the credit rule above; the bench asserts this.
  - m_tready low: reads stall within FIFO_DEPTH words; no word is lost or duplicated.
  - A FIFO push and pop in the same cycle is legal; the count is unchanged.
- Counter widths: the address index uses RAM_AW bits. The beat counter uses RAM_AW+2 bits, so word_cnt = 2^RAM_AW-1 must not overflow it.

Test Plan:
- Contiguous transfer:
  - Setup: preload bank b address a with value 16*b+a; base_addr=0, word_cnt=2, m_tready=1.
  - Expected: beats 0,16,32,48,1,17,33,49 on consecutive cycles.
  - First beat at cycle N+3 (RD_LAT=1); m_tlast only on 49; done one cycle after the last beat; busy low afterwards.
- Backpressure:
  - Setup: same preload; word_cnt=8; m_tready pattern 1,0,0,1 repeating, plus one 20-cycle low stretch.
  - Expected: exact 32-word sequence with no loss or duplication.
  - res_enb_x stops within FIFO_DEPTH issues of the stall, and inflight+count never exceeds 4.
- Zero length: start with word_cnt=0 -> done pulse at cycle N+1; no res_enb_x, no m_tvalid, busy never rises.
- Address wrap: base_addr=131071, word_cnt=2 -> reads at address 131071 (banks 0..3), then address 0; 8 beats.
- Mid-stream reset:
  - Stimulus: rst=1 after the 3rd beat of a word_cnt=4 transfer.
  - Expected: next cycle all outputs are 0 and state is IDLE; a fresh start with word_cnt=1 returns 4 correct beats starting from the bank-0 value.
- Start while busy: pulse start with a different base during RUN -> ignored; the original sequence completes and exactly one done pulse is produced.
